// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state type
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/uart_rx_param_if.sv
// rtl/uart_rx_param_if.sv - received-word ready/valid port with per-word error flags
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_o;
    logic                 valid_o;
    logic                 ready_i;
    logic                 frame_error_o;
    logic                 parity_error_o;
    logic                 overrun_o;

    modport master (
        output data_o,
        output valid_o,
        output frame_error_o,
        output parity_error_o,
        output overrun_o,
        input  ready_i
    );

    modport slave (
        input  data_o,
        input  valid_o,
        input  frame_error_o,
        input  parity_error_o,
        input  overrun_o,
        output ready_i
    );
endinterface

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - multi-flop synchroniser for an idle-high async line
module uart_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line,
    output logic synced
);
    logic [STAGES-1:0] chain;

    // Shift the async line through the chain; resets to the idle (high) level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], line};
        end
    end

    assign synced = chain[STAGES-1];
endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver; UART_RX_MAJORITY_EN enables 3-sample voting
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = PARITY_NONE,
    parameter int STOP_BITS    = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               serial_i,
    output logic               busy_o,
    uart_rx_param_if.master    rx
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int MID   = CLKS_PER_BIT / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int SAMPLE_PT = MID + 1;
`else
    localparam int SAMPLE_PT = MID;
`endif
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SAMPLE_PT);
    localparam logic [3:0]       DATA_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST  = 4'(STOP_BITS - 1);

    logic                 line;
    rx_state_t            state;
    rx_state_t            state_n;
    logic [CNT_W-1:0]     cnt;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_err;
    logic                 frm_err;
    logic                 done;
    logic                 finish;
    logic                 sample_now;
    logic                 bit_val;
    logic                 par_exp;

    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 ferr_q;
    logic                 perr_q;
    logic                 ovr_q;

    uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk    (clock_i),
        .rst_n  (reset_i),
        .line   (serial_i),
        .synced (line)
    );

    // The bit counter free-runs across the whole frame, so every bit is
    // sampled at the same phase as the start-bit midpoint.
    assign sample_now = (state != RX_IDLE) && (cnt == CNT_SAMPLE);

`ifdef UART_RX_MAJORITY_EN
    logic s_early;
    logic s_mid;

    // Capture the two samples preceding the decision point for the vote.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            s_early <= 1'b1;
            s_mid   <= 1'b1;
        end else begin
            if (cnt == CNT_W'(MID - 1)) s_early <= line;
            if (cnt == CNT_W'(MID))     s_mid   <= line;
        end
    end

    assign bit_val = (s_early & s_mid) | (s_early & line) | (s_mid & line);
`else
    assign bit_val = line;
`endif

    assign par_exp = (PARITY == PARITY_ODD) ? ~(^shreg) : (^shreg);

    // State register.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) state <= RX_IDLE;
        else          state <= state_n;
    end

    // Next-state decode and the last-stop-sample strobe.
    always_comb begin
        state_n = state;
        finish  = 1'b0;
        case (state)
            RX_IDLE:      if (!line) state_n = RX_START;
            RX_START:     if (sample_now) state_n = bit_val ? RX_IDLE : RX_DATA;
            RX_DATA:      if (sample_now && bit_idx == DATA_LAST)
                              state_n = (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
            RX_PARITY:    if (sample_now) state_n = RX_STOP;
            RX_STOP:      if (sample_now && bit_idx == STOP_LAST) begin
                              finish  = 1'b1;
                              state_n = (frm_err || !bit_val) ? RX_WAIT_HIGH : RX_IDLE;
                          end
            RX_WAIT_HIGH: if (line) state_n = RX_IDLE;
            default:      state_n = RX_IDLE;
        endcase
    end

    // Frame datapath: bit timing, shift register and latched error flags.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_err <= 1'b0;
            frm_err <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= finish;
            if (state == RX_IDLE)   cnt <= '0;
            else if (cnt == CNT_LAST) cnt <= '0;
            else                    cnt <= cnt + 1'b1;

            if (state_n != state) bit_idx <= '0;
            else if (sample_now && (state == RX_DATA || state == RX_STOP))
                bit_idx <= bit_idx + 4'd1;

            if (state == RX_START) begin
                par_err <= 1'b0;
                frm_err <= 1'b0;
            end
            if (state == RX_DATA && sample_now)
                shreg <= {bit_val, shreg[DATA_BITS-1:1]};
            if (state == RX_PARITY && sample_now)
                par_err <= (bit_val != par_exp);
            if (state == RX_STOP && sample_now && !bit_val)
                frm_err <= 1'b1;
        end
    end

    // Output register: load on completion unless an unread word would be lost.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            if (done) begin
                if (valid_q && !rx.ready_i) begin
                    ovr_q <= 1'b1;
                end else begin
                    data_q  <= shreg;
                    ferr_q  <= frm_err;
                    perr_q  <= par_err;
                    valid_q <= 1'b1;
                end
            end else if (valid_q && rx.ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx.data_o         = data_q;
    assign rx.valid_o        = valid_q;
    assign rx.frame_error_o  = ferr_q;
    assign rx.parity_error_o = perr_q;
    assign rx.overrun_o      = ovr_q;
    assign busy_o            = (state != RX_IDLE);
endmodule
